disp_ctrl: RTL and testbench

- Display scheduler between the 8-digit seven-segment decoder and two requesters.
- Source A is the keypad entry buffer and is the default, always-present source.
- Source B is a message/result source that requests the display for a timed hold window, optionally blinking.
- Inserts blank gap frames on every source switch. Applies leading-zero suppression to A. All outputs are registered.

---
 rtl/disp_ctrl.sv | 179 +++++++++++++++++
 tb/tb_disp_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/disp_ctrl.sv
// Display scheduler: arbitrates the 8-digit seven-segment display between the
// keypad buffer (A, default) and a timed message source (B) with blank gaps.
module disp_ctrl #(
  parameter int HOLD  = 200,
  parameter int GAP   = 10,
  parameter int BLINK = 25,
  parameter int LZ_EN = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [7:0][3:0] a_digits,
  input  logic [7:0]      a_flt_pt,
  input  logic            b_req,
  input  logic [7:0][3:0] b_digits,
  input  logic [7:0]      b_flt_pt,
  input  logic            b_blink,
  output logic            b_ack,
  output logic [7:0][3:0] digits,
  output logic [7:0]      flt_pt,
  output logic [7:0]      blank,
  output logic            src_b
);

  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK + 1);

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
  localparam logic [BLK_W-1:0] BLINK_LD = BLK_W'(BLINK - 1);

  typedef enum logic [1:0] {SHOW_A, GAP_TO_B, SHOW_B, GAP_TO_A} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLK_W-1:0]  bcnt_q, bcnt_d;
  logic              phase_q, phase_d;   // 1 = invisible half of the blink
  logic [7:0][3:0]   bdig_q, bdig_d;
  logic [7:0]        bfp_q, bfp_d;
  logic              bblk_q, bblk_d;
  logic [7:0][3:0]   digits_q, digits_d;
  logic [7:0]        flt_pt_q, flt_pt_d;
  logic [7:0]        blank_q, blank_d;
  logic              ack_q, ack_d;
  logic              src_b_q, src_b_d;
  logic              grant;
  logic              lead;
  logic [7:0]        lz;

  // Leading-zero mask: a digit stays dark while it and everything above it is
  // zero with no decimal point; digit 0 always shows.
  always_comb begin
    lead = 1'b1;
    lz   = 8'h00;
    for (int i = 7; i >= 1; i--) begin
      lead  = lead & (a_digits[i] == 4'd0) & ~a_flt_pt[i];
      lz[i] = lead;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    bdig_d   = bdig_q;
    bfp_d    = bfp_q;
    bblk_d   = bblk_q;
    digits_d = digits_q;
    flt_pt_d = flt_pt_q;
    blank_d  = 8'hFF;
    ack_d    = 1'b0;
    src_b_d  = 1'b0;
    grant    = 1'b0;

    case (state_q)
      SHOW_A: begin
        digits_d = a_digits;
        flt_pt_d = a_flt_pt;
        blank_d  = (LZ_EN != 0) ? lz : 8'h00;
        if (b_req) begin
          grant   = 1'b1;
          cnt_d   = GAP_LD;
          state_d = GAP_TO_B;
        end
      end
      GAP_TO_B: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          phase_d = 1'b0;
          bcnt_d  = BLINK_LD;
          state_d = SHOW_B;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHOW_B: begin
        digits_d = bdig_q;
        flt_pt_d = bfp_q;
        src_b_d  = 1'b1;
        blank_d  = (bblk_q && phase_q) ? 8'hFF : 8'h00;
        if (bcnt_q == '0) begin
          bcnt_d  = BLINK_LD;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
        // A new request beats hold expiry and re-grants without a gap.
        if (b_req) begin
          grant   = 1'b1;
          cnt_d   = HOLD_LD;
          phase_d = 1'b0;
          bcnt_d  = BLINK_LD;
        end else if (cnt_q == '0) begin
          cnt_d   = GAP_LD;
          state_d = GAP_TO_A;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP_TO_A: begin
        if (b_req) begin
          grant   = 1'b1;
          cnt_d   = GAP_LD;
          state_d = GAP_TO_B;
        end else if (cnt_q == '0) begin
          state_d = SHOW_A;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = SHOW_A;
    endcase

    if (grant) begin
      bdig_d = b_digits;
      bfp_d  = b_flt_pt;
      bblk_d = b_blink;
      ack_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= SHOW_A;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      bdig_q   <= '0;
      bfp_q    <= '0;
      bblk_q   <= 1'b0;
      digits_q <= '0;
      flt_pt_q <= '0;
      blank_q  <= 8'hFF;
      ack_q    <= 1'b0;
      src_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      bdig_q   <= bdig_d;
      bfp_q    <= bfp_d;
      bblk_q   <= bblk_d;
      digits_q <= digits_d;
      flt_pt_q <= flt_pt_d;
      blank_q  <= blank_d;
      ack_q    <= ack_d;
      src_b_q  <= src_b_d;
    end
  end

  assign b_ack  = ack_q;
  assign digits = digits_q;
  assign flt_pt = flt_pt_q;
  assign blank  = blank_q;
  assign src_b  = src_b_q;

endmodule

// File: tb/tb_disp_ctrl.sv
// Directed bench for disp_ctrl with HOLD=4, GAP=2, BLINK=2, LZ_EN=1.
module tb_disp_ctrl;

  logic            CLK = 1'b0;
  logic            RST;
  logic [7:0][3:0] a_digits;
  logic [7:0]      a_flt_pt;
  logic            b_req;
  logic [7:0][3:0] b_digits;
  logic [7:0]      b_flt_pt;
  logic            b_blink;
  logic            b_ack;
  logic [7:0][3:0] digits;
  logic [7:0]      flt_pt;
  logic [7:0]      blank;
  logic            src_b;

  int nvec = 0;
  int nerr = 0;

  disp_ctrl #(.HOLD(4), .GAP(2), .BLINK(2), .LZ_EN(1)) dut (
    .CLK(CLK), .RST(RST),
    .a_digits(a_digits), .a_flt_pt(a_flt_pt),
    .b_req(b_req), .b_digits(b_digits), .b_flt_pt(b_flt_pt), .b_blink(b_blink),
    .b_ack(b_ack), .digits(digits), .flt_pt(flt_pt), .blank(blank), .src_b(src_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance one frame and check every displayed output.
  task automatic frm(input string tag, input logic ack, input logic src,
                     input logic [7:0] blk, input logic [31:0] dig);
    tick();
    chk({tag, ".ack"},    64'(b_ack),  64'(ack));
    chk({tag, ".src_b"},  64'(src_b),  64'(src));
    chk({tag, ".blank"},  64'(blank),  64'(blk));
    chk({tag, ".digits"}, 64'(digits), 64'(dig));
  endtask

  initial begin
    RST = 1'b1; a_digits = '0; a_flt_pt = '0;
    b_req = 1'b0; b_digits = '0; b_flt_pt = '0; b_blink = 1'b0;
    tick(); tick();
    chk("rst.blank",  64'(blank),  64'hFF);
    chk("rst.digits", 64'(digits), 64'h0);
    chk("rst.flt_pt", 64'(flt_pt), 64'h0);
    chk("rst.ack",    64'(b_ack),  64'h0);
    chk("rst.src_b",  64'(src_b),  64'h0);

    // Leading-zero suppression on A
    RST = 1'b0; a_digits = 32'h0000_0120;
    frm("lz120", 1'b0, 1'b0, 8'hF8, 32'h0000_0120);
    a_digits = '0; a_flt_pt = 8'h02;
    frm("lzdp", 1'b0, 1'b0, 8'hFC, 32'h0);
    chk("lzdp.flt_pt", 64'(flt_pt), 64'h02);

    // Plain B grant, no blink
    a_digits = 32'h7; a_flt_pt = '0;
    b_digits = 32'h0000_0E44; b_blink = 1'b0; b_req = 1'b1;
    frm("g1.ack", 1'b1, 1'b0, 8'hFE, 32'h7);
    b_req = 1'b0;
    frm("g1.gapb0", 1'b0, 1'b0, 8'hFF, 32'h7);
    frm("g1.gapb1", 1'b0, 1'b0, 8'hFF, 32'h7);
    for (int i = 0; i < 4; i++) frm("g1.showb", 1'b0, 1'b1, 8'h00, 32'h0000_0E44);
    frm("g1.gapa0", 1'b0, 1'b0, 8'hFF, 32'h0000_0E44);
    frm("g1.gapa1", 1'b0, 1'b0, 8'hFF, 32'h0000_0E44);
    frm("g1.backa", 1'b0, 1'b0, 8'hFE, 32'h7);

    // Blinking B
    b_digits = 32'h1234_5678; b_blink = 1'b1; b_req = 1'b1;
    frm("g2.ack", 1'b1, 1'b0, 8'hFE, 32'h7);
    b_req = 1'b0; b_blink = 1'b0;
    frm("g2.gapb0", 1'b0, 1'b0, 8'hFF, 32'h7);
    frm("g2.gapb1", 1'b0, 1'b0, 8'hFF, 32'h7);
    frm("g2.blk0", 1'b0, 1'b1, 8'h00, 32'h1234_5678);
    frm("g2.blk1", 1'b0, 1'b1, 8'h00, 32'h1234_5678);
    frm("g2.blk2", 1'b0, 1'b1, 8'hFF, 32'h1234_5678);
    frm("g2.blk3", 1'b0, 1'b1, 8'hFF, 32'h1234_5678);
    frm("g2.gapa0", 1'b0, 1'b0, 8'hFF, 32'h1234_5678);
    frm("g2.gapa1", 1'b0, 1'b0, 8'hFF, 32'h1234_5678);
    frm("g2.backa", 1'b0, 1'b0, 8'hFE, 32'h7);

    // Re-grant during SHOW_B: no gap, hold restarts
    b_digits = 32'hAAAA_0001; b_req = 1'b1;
    frm("g3.ack", 1'b1, 1'b0, 8'hFE, 32'h7);
    b_req = 1'b0;
    frm("g3.gapb0", 1'b0, 1'b0, 8'hFF, 32'h7);
    frm("g3.gapb1", 1'b0, 1'b0, 8'hFF, 32'h7);
    frm("g3.b1", 1'b0, 1'b1, 8'h00, 32'hAAAA_0001);
    frm("g3.b2", 1'b0, 1'b1, 8'h00, 32'hAAAA_0001);
    b_digits = 32'h0000_0BEE; b_req = 1'b1;
    frm("g3.reack", 1'b1, 1'b1, 8'h00, 32'hAAAA_0001);
    b_req = 1'b0; b_digits = '0;
    for (int i = 0; i < 4; i++) frm("g3.newb", 1'b0, 1'b1, 8'h00, 32'h0000_0BEE);
    frm("g3.gapa0", 1'b0, 1'b0, 8'hFF, 32'h0000_0BEE);
    frm("g3.gapa1", 1'b0, 1'b0, 8'hFF, 32'h0000_0BEE);
    frm("g3.backa", 1'b0, 1'b0, 8'hFE, 32'h7);

    // b_req held through GAP_TO_B, then reset mid-hold
    b_digits = 32'h0000_0055; b_req = 1'b1;
    frm("g4.ack", 1'b1, 1'b0, 8'hFE, 32'h7);
    frm("g4.gapb0", 1'b0, 1'b0, 8'hFF, 32'h7);
    frm("g4.gapb1", 1'b0, 1'b0, 8'hFF, 32'h7);
    b_req = 1'b0;
    frm("g4.b1", 1'b0, 1'b1, 8'h00, 32'h0000_0055);
    frm("g4.b2", 1'b0, 1'b1, 8'h00, 32'h0000_0055);
    RST = 1'b1;
    frm("g4.rst", 1'b0, 1'b0, 8'hFF, 32'h0);
    RST = 1'b0; a_digits = 32'h0000_3000;
    frm("g4.a0", 1'b0, 1'b0, 8'hF0, 32'h0000_3000);
    for (int i = 0; i < 6; i++) frm("g4.stay", 1'b0, 1'b0, 8'hF0, 32'h0000_3000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
